restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//   Sequential unsigned integer divider: quotient = dividend / divisor, remainder = dividend % divisor.
//   Inverse companion to the combinational ripple adder: iterative shift/trial-subtract, one quotient bit per clock.
//   Sits behind a start/busy/done handshake so PS-side or fabric controllers can issue one division at a time.
// PARAMETERS
//   WIDTH  4  operand, quotient and remainder width in bits (>= 2)
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request; sampled only while busy==0
//   dividend     in   WIDTH  unsigned numerator, captured on accepted start
//   divisor      in   WIDTH  unsigned denominator, captured on accepted start
//   busy         out  1      high while an iteration sequence is in progress
//   done         out  1      one-cycle pulse: quotient/remainder/div_by_zero valid
//   quotient     out  WIDTH  result, held until next completion
//   remainder    out  WIDTH  result, held until next completion
//   div_by_zero  out  1      set with done when captured divisor was 0, held until next completion
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
//   States: IDLE -> CALC on accepted start with divisor!=0; CALC -> IDLE after WIDTH iterations.
//   Accept: start==1 && busy==0 at edge E0; operands latched into internal regs; later input changes ignored.
//   divisor==0 at E0: no CALC; after E0 done=1, div_by_zero=1, quotient=all ones, remainder=dividend; busy stays 0.
//   divisor!=0 at E0: after E0 busy=1, partial remainder P=0 (WIDTH+1 bits), shift reg Q=dividend, count=0.
//   Iteration (each edge in CALC): P'={P[W-1:0],Q[W-1]}; D=P'-{1'b0,divisor} (WIDTH+1 bits);
//     borrow (D[W])==0 -> P=D, shift 1 into Q LSB; else P=P', shift 0 into Q LSB; count++.
//   Final iteration at edge E_W (W edges after E0): quotient<=Q result, remainder<=P[W-1:0], div_by_zero<=0,
//     done<=1, busy<=0, state<=IDLE. busy high for exactly WIDTH cycles; latency start->done = WIDTH clocks.
//   done is high exactly one cycle; it is never high together with busy.
//   start while busy==1: ignored, no effect on operation or outputs.
//   start in the cycle done==1: accepted (busy==0); results stay valid that cycle, new op proceeds normally.
//   quotient/remainder/div_by_zero are not cleared by start; they change only at completion or reset.
//   Reset mid-CALC: operation abandoned, all outputs return to reset values immediately; no done pulse.
//   Arithmetic: remainder < divisor always; quotient*divisor+remainder == dividend for divisor!=0.
// STRUCTURE
//   Shared package: state encoding localparams (ST_IDLE, ST_CALC), DIV_WIDTH_DEFAULT = 4.
//   Counter width = $clog2(WIDTH+1).
//   One sub-module: trial_subtractor -- combinational (WIDTH+1)-bit ripple subtract, ports a, b, diff, borrow;
//     built from a per-bit full-subtractor generate chain, borrow-in of bit 0 tied to 0.
//   Top holds FSM, counter, P/Q/divisor registers and output registers; no combinational path input->output.
// TESTING (WIDTH=4)
//   13/3: start 1 cycle -> busy 4 cycles, done pulse at E0+4, quotient=4, remainder=1, div_by_zero=0.
//   15/1 -> q=15 r=0; 0/5 -> q=0 r=0; 3/7 -> q=0 r=3; 15/15 -> q=1 r=0; all at exactly 4-clock latency.
//   9/0 -> done after E0 (1 clock), busy never high, q=15 r=9 div_by_zero=1; next 8/2 clears flag, q=4 r=0.
//   Start 13/3, pulse start with 6/2 at cycles 1-3 -> ignored; result q=4 r=1; exactly one done pulse.
//   Start 12/5, deassert rst_n after 2 iterations -> outputs all 0 asynchronously, no done; after release 7/2 -> q=3 r=1.
//   Back-to-back: start held high continuously -> done every 5 cycles; exhaustive sweep of all 256 operand pairs vs model.

Source files
------------

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding, the default
// operand width and the iteration counter sizing rule.
package restoring_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } div_state_e;

    // The counter must reach WIDTH-1; sized as $clog2(WIDTH+1) so it also holds WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_trial_subtractor.sv
// Combinational ripple subtractor used for the trial subtract of each
// divider iteration: diff = a - b, borrow = final ripple borrow-out.
module trial_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] br;

    assign br[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fs
            assign diff[i]  = a[i] ^ b[i] ^ br[i];
            assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    endgenerate

    assign borrow = br[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake; divide-by-zero completes in one clock.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // The partial remainder always stays below the divisor, so WIDTH bits hold it;
    // the extra trial bit is formed by the shift below.
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_d, rem_d;
    logic             dbz_d, done_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             trial_neg;
    logic [WIDTH-1:0] p_step;
    logic [WIDTH-1:0] q_step;

    assign trial_a = {p_q, q_q[WIDTH-1]};

    trial_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .a      (trial_a),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Borrow-out and the difference sign bit agree for in-range operands.
    assign trial_neg = trial_borrow | trial_diff[WIDTH];
    assign p_step    = trial_neg ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign q_step    = {q_q[WIDTH-2:0], ~trial_neg};

    assign busy = (state_q == ST_CALC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quotient;
        rem_d   = remainder;
        dbz_d   = div_by_zero;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        quot_d = '1;
                        rem_d  = dividend;
                    end else begin
                        state_d = ST_CALC;
                        p_d     = '0;
                        q_d     = dividend;
                        dvs_d   = divisor;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CALC: begin
                p_d   = p_step;
                q_d   = q_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    quot_d  = q_step;
                    rem_d   = p_step;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done        <= done_d;
            quotient    <= quot_d;
            remainder   <= rem_d;
            div_by_zero <= dbz_d;
        end
    end

    // Working registers are qualified by the FSM and need no reset.
    always_ff @(posedge clk) begin
        p_q   <= p_d;
        q_q   <= q_d;
        dvs_q <= dvs_d;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive bench for restoring_divider (WIDTH=4) with a queue
// scoreboard of expected quotient/remainder/div_by_zero.
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   n_done    = 0;
    int   n_overlap = 0;

    always #5 clk = ~clk;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always @(negedge clk) begin
        if (done) n_done++;
        if (done && busy) n_overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
    endtask

    // lat counts negedges after the accepting edge up to and including the one showing done.
    task automatic wait_done(input string tag, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end while (!done && lat < 20);
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"},   32'(quotient),    32'(e.q));
            check({tag, "_r"},   32'(remainder),   32'(e.r));
            check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int lat, nbusy;
        drive(a, b);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, lat, nbusy);
        check({tag, "_lat"},  32'(lat),   (b == '0) ? 32'd1 : 32'(W + 1));
        check({tag, "_busy"}, 32'(nbusy), (b == '0) ? 32'd0 : 32'(W));
        compare(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, nbusy, done_before;
        logic [W-1:0] a, b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_done", 32'(done),        32'd0);
        check("rst_q",    32'(quotient),    32'd0);
        check("rst_r",    32'(remainder),   32'd0);
        check("rst_dbz",  32'(div_by_zero), 32'd0);

        run_op(4'd13, 4'd3,  "d13_3");
        run_op(4'd15, 4'd1,  "d15_1");
        run_op(4'd0,  4'd5,  "d0_5");
        run_op(4'd3,  4'd7,  "d3_7");
        run_op(4'd15, 4'd15, "d15_15");
        run_op(4'd9,  4'd0,  "d9_0");
        run_op(4'd8,  4'd2,  "d8_2");

        // Start pulses while busy must be ignored.
        done_before = n_done;
        drive(4'd13, 4'd3);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start    = 1'b1;
            dividend = 4'd6;
            divisor  = 4'd2;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", lat, nbusy);
        compare("ign");
        repeat (6) @(negedge clk);
        check("ign_done_count", 32'(n_done - done_before), 32'd1);
        check("ign_busy_idle",  32'(busy),                 32'd0);

        // Reset during CALC abandons the operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy),        32'd0);
        check("arst_done", 32'(done),        32'd0);
        check("arst_q",    32'(quotient),    32'd0);
        check("arst_r",    32'(remainder),   32'd0);
        check("arst_dbz",  32'(div_by_zero), 32'd0);
        done_before = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_no_done", 32'(n_done - done_before), 32'd0);
        run_op(4'd7, 4'd2, "d7_2");

        // Exhaustive sweep with start held high: each new pair is accepted on the edge after done.
        @(negedge clk);
        start    = 1'b1;
        dividend = '0;
        divisor  = '0;
        sb.push_back(model('0, '0));
        for (int k = 0; k < 256; k++) begin
            b = 4'(k % 16);
            wait_done("sweep", lat, nbusy);
            check("sweep_lat", 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
            compare("sweep");
            if (k < 255) begin
                a        = 4'((k + 1) / 16);
                b        = 4'((k + 1) % 16);
                dividend = a;
                divisor  = b;
                sb.push_back(model(a, b));
            end else begin
                start = 1'b0;
            end
        end
        repeat (8) @(negedge clk);

        check("sb_drained",   32'(sb.size()), 32'd0);
        check("done_busy_ov", 32'(n_overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
